// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator bank: operation encoding and
// default geometry constants.
package accumulator_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_CLEAR = 3'b010,
        OP_SHL   = 3'b011,
        OP_SHR   = 3'b100,
        OP_ROL   = 3'b101,
        OP_ROR   = 3'b110,
        OP_INC   = 3'b111
    } acc_op_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/accumulator_bank_op_unit.sv
// Combinational datapath for one accumulator operation: given the current
// stored value it produces the value to write back and the resulting carry.
module acc_op_unit
    import accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur_value,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             serial_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] next_value,
    output logic             next_carry,
    output logic             write_en
);

    logic [WIDTH:0] inc_sum_s;

    // Increment with one extra bit so the wrap out of all-ones shows as carry.
    always_comb begin
        inc_sum_s = {1'b0, cur_value} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Next value / carry selection; HOLD keeps everything and suppresses the write.
    always_comb begin
        next_value = cur_value;
        next_carry = carry_in;
        write_en   = 1'b1;
        case (acc_op_t'(op))
            OP_HOLD: begin
                write_en = 1'b0;
            end
            OP_LOAD: begin
                next_value = bus_in;
            end
            OP_CLEAR: begin
                next_value = {WIDTH{1'b0}};
                next_carry = 1'b0;
            end
            OP_SHL: begin
                next_value = {cur_value[WIDTH-2:0], serial_in};
                next_carry = cur_value[WIDTH-1];
            end
            OP_SHR: begin
                next_value = {serial_in, cur_value[WIDTH-1:1]};
                next_carry = cur_value[0];
            end
            OP_ROL: begin
                next_value = {cur_value[WIDTH-2:0], cur_value[WIDTH-1]};
                next_carry = cur_value[WIDTH-1];
            end
            OP_ROR: begin
                next_value = {cur_value[0], cur_value[WIDTH-1:1]};
                next_carry = cur_value[0];
            end
            OP_INC: begin
                next_value = inc_sum_s[WIDTH-1:0];
                next_carry = inc_sum_s[WIDTH];
            end
            default: begin
                next_value = cur_value;
                next_carry = carry_in;
                write_en   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of DEPTH accumulators sharing one operation unit and one set of
// status flags. The selected accumulator is read combinationally for the
// ALU and can be driven onto the W bus through a registered stage, which
// always presents the value from before any write in the same cycle.
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SELW  = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             serial_in,
    input  logic             output_to_bus,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic [WIDTH-1:0] ula_input,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             negative_flag
);

    logic [WIDTH-1:0] acc_r [DEPTH];
    logic [WIDTH-1:0] bus_out_r;
    logic             bus_drive_r;
    logic             carry_r;
    logic             zero_r;
    logic             negative_r;

    logic [WIDTH-1:0] cur_value_s;
    logic [WIDTH-1:0] next_value_s;
    logic             next_carry_s;
    logic             write_en_s;

    // Current value of the selected accumulator, no bypass of in-flight ops.
    always_comb begin
        cur_value_s = acc_r[sel];
    end

    acc_op_unit #(
        .WIDTH(WIDTH)
    ) u_op_unit (
        .op        (op),
        .cur_value (cur_value_s),
        .bus_in    (bus_in),
        .serial_in (serial_in),
        .carry_in  (carry_r),
        .next_value(next_value_s),
        .next_carry(next_carry_s),
        .write_en  (write_en_s)
    );

    // Accumulator storage: only the selected entry is written, reset clears all.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                acc_r[i] <= {WIDTH{1'b0}};
            end
        end else if (write_en_s) begin
            acc_r[sel] <= next_value_s;
        end else begin
            acc_r[sel] <= acc_r[sel];
        end
    end

    // Status flags reflect the value written by the last non-HOLD op.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_r    <= 1'b0;
            zero_r     <= 1'b1;
            negative_r <= 1'b0;
        end else if (write_en_s) begin
            carry_r    <= next_carry_s;
            zero_r     <= (next_value_s == {WIDTH{1'b0}});
            negative_r <= next_value_s[WIDTH-1];
        end else begin
            carry_r    <= carry_r;
            zero_r     <= zero_r;
            negative_r <= negative_r;
        end
    end

    // Registered bus drive stage; captures the pre-write value and zeros when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_out_r   <= {WIDTH{1'b0}};
            bus_drive_r <= 1'b0;
        end else if (output_to_bus) begin
            bus_out_r   <= cur_value_s;
            bus_drive_r <= 1'b1;
        end else begin
            bus_out_r   <= {WIDTH{1'b0}};
            bus_drive_r <= 1'b0;
        end
    end

    // Output mapping.
    always_comb begin
        ula_input     = cur_value_s;
        bus_out       = bus_out_r;
        bus_drive     = bus_drive_r;
        carry_flag    = carry_r;
        zero_flag     = zero_r;
        negative_flag = negative_r;
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: directed scenarios from the
// requirements plus randomized traffic against an arithmetic reference model.
module tb_accumulator_bank;

    logic       clock;
    logic       reset;
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] bus_in;
    logic       serial_in;
    logic       output_to_bus;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [7:0] ula_input;
    logic       carry_flag;
    logic       zero_flag;
    logic       negative_flag;

    logic        reset2;
    logic [2:0]  op2;
    logic [2:0]  sel2;
    logic [15:0] bus_in2;
    logic        serial_in2;
    logic        output_to_bus2;
    logic [15:0] bus_out2;
    logic        bus_drive2;
    logic [15:0] ula_input2;
    logic        carry_flag2;
    logic        zero_flag2;
    logic        negative_flag2;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state (plain integers).
    int m_acc [4];
    int m_carry, m_zero, m_neg, m_bo, m_bd;

    accumulator_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .op(op), .sel(sel), .bus_in(bus_in),
        .serial_in(serial_in), .output_to_bus(output_to_bus), .bus_out(bus_out),
        .bus_drive(bus_drive), .ula_input(ula_input), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .negative_flag(negative_flag)
    );

    accumulator_bank #(.WIDTH(16), .DEPTH(8)) dut16 (
        .clock(clock), .reset(reset2), .op(op2), .sel(sel2), .bus_in(bus_in2),
        .serial_in(serial_in2), .output_to_bus(output_to_bus2), .bus_out(bus_out2),
        .bus_drive(bus_drive2), .ula_input(ula_input2), .carry_flag(carry_flag2),
        .zero_flag(zero_flag2), .negative_flag(negative_flag2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the op definitions.
    task automatic model_step(input int rst, input int o, input int s, input int b,
                              input int sin, input int otb);
        int old, nv, c;
        if (rst != 0) begin
            for (int i = 0; i < 4; i++) m_acc[i] = 0;
            m_carry = 0; m_zero = 1; m_neg = 0; m_bo = 0; m_bd = 0;
            return;
        end
        old  = m_acc[s];
        m_bd = otb;
        m_bo = (otb != 0) ? old : 0;
        nv = old;
        c  = m_carry;
        case (o)
            1: nv = b;
            2: begin nv = 0; c = 0; end
            3: begin nv = (old * 2 + sin) % 256;      c = old / 128; end
            4: begin nv = sin * 128 + old / 2;        c = old % 2;   end
            5: begin nv = (old * 2 + old / 128) % 256; c = old / 128; end
            6: begin nv = (old % 2) * 128 + old / 2; c = old % 2;   end
            7: begin nv = (old + 1) % 256;            c = (old == 255) ? 1 : 0; end
            default: ;
        endcase
        if (o != 0) begin
            m_acc[s] = nv;
            m_carry  = c;
            m_zero   = (nv == 0) ? 1 : 0;
            m_neg    = nv / 128;
        end
    endtask

    // Drive one cycle, advance the model, then compare all registered outputs.
    task automatic cycle(input int rst, input int o, input int s, input int b,
                         input int sin, input int otb);
        reset         = rst[0];
        op            = o[2:0];
        sel           = s[1:0];
        bus_in        = b[7:0];
        serial_in     = sin[0];
        output_to_bus = otb[0];
        @(posedge clock);
        model_step(rst, o, s, b, sin, otb);
        #1;
        check_eq("bus_out",   {24'd0, bus_out},       m_bo);
        check_eq("bus_drive", {31'd0, bus_drive},     m_bd);
        check_eq("carry",     {31'd0, carry_flag},    m_carry);
        check_eq("zero",      {31'd0, zero_flag},     m_zero);
        check_eq("negative",  {31'd0, negative_flag}, m_neg);
        check_eq("ula",       {24'd0, ula_input},     m_acc[s]);
    endtask

    // Read every accumulator through the combinational ula_input port.
    task automatic peek_all();
        for (int k = 0; k < 4; k++) begin
            sel = k[1:0];
            #1;
            check_eq($sformatf("acc%0d", k), {24'd0, ula_input}, m_acc[k]);
        end
    endtask

    initial begin
        reset = 1'b1; op = 3'd0; sel = 2'd0; bus_in = 8'd0; serial_in = 1'b0;
        output_to_bus = 1'b0;
        reset2 = 1'b1; op2 = 3'd0; sel2 = 3'd0; bus_in2 = 16'd0; serial_in2 = 1'b0;
        output_to_bus2 = 1'b0;
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_carry = 0; m_zero = 1; m_neg = 0; m_bo = 0; m_bd = 0;

        // Reset state.
        cycle(1, 0, 0, 8'hA5, 1, 1);
        check_eq("rst_zero", {31'd0, zero_flag}, 32'd1);
        peek_all();

        // LOAD 0x5A to acc2 then drive it on the bus.
        cycle(0, 1, 2, 8'h5A, 0, 0);
        cycle(0, 0, 2, 0, 0, 1);
        check_eq("r35_bus", {24'd0, bus_out}, 32'h5A);
        check_eq("r35_drv", {31'd0, bus_drive}, 32'd1);
        peek_all();
        cycle(0, 0, 2, 0, 0, 0);
        check_eq("r35_idle", {24'd0, bus_out}, 32'h0);

        // SHL on 0x81, ROR on 0x01.
        cycle(0, 1, 1, 8'h81, 0, 0);
        cycle(0, 3, 1, 0, 0, 0);
        check_eq("r36_shl", {24'd0, ula_input}, 32'h02);
        check_eq("r36_c",   {31'd0, carry_flag}, 32'd1);
        cycle(0, 1, 1, 8'h01, 0, 0);
        cycle(0, 6, 1, 0, 0, 0);
        check_eq("r36_ror", {24'd0, ula_input}, 32'h80);
        check_eq("r36_n",   {31'd0, negative_flag}, 32'd1);

        // INC wrap and INC again.
        cycle(0, 1, 0, 8'hFF, 0, 0);
        cycle(0, 7, 0, 0, 0, 0);
        check_eq("r37_wrap", {30'd0, carry_flag, zero_flag}, 32'd3);
        cycle(0, 7, 0, 0, 0, 0);
        check_eq("r37_inc", {24'd0, ula_input}, 32'h01);
        check_eq("r37_cz",  {30'd0, carry_flag, zero_flag}, 32'd0);

        // LOAD leaves carry alone; HOLD leaves flags alone.
        cycle(0, 2, 3, 0, 0, 0);
        cycle(0, 1, 3, 8'h10, 0, 0);
        // Read-before-write on the bus path.
        cycle(0, 1, 3, 8'h77, 0, 1);
        check_eq("r38_bus", {24'd0, bus_out}, 32'h10);
        check_eq("r38_ula", {24'd0, ula_input}, 32'h77);

        // Reset in the middle of traffic.
        cycle(0, 1, 0, 8'h33, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 8'hAA, 0, 1);
        check_eq("r39_drv", {31'd0, bus_drive}, 32'd0);
        peek_all();
        cycle(0, 1, 1, 8'h12, 0, 1);
        check_eq("r31_first", {24'd0, ula_input}, 32'h12);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 40) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if (n % 16 == 15) peek_all();
        end

        // Wide build: 16 bits, 8 accumulators.
        @(posedge clock);
        #1;
        reset2 = 1'b0; op2 = 3'd1; sel2 = 3'd7; bus_in2 = 16'h8000;
        @(posedge clock);
        #1;
        check_eq("w_load", {16'd0, ula_input2}, 32'h8000);
        op2 = 3'd3; serial_in2 = 1'b1;
        @(posedge clock);
        #1;
        check_eq("w_shl", {16'd0, ula_input2}, 32'h0001);
        check_eq("w_c",   {31'd0, carry_flag2}, 32'd1);
        op2 = 3'd0; sel2 = 3'd6;
        #1;
        check_eq("w_acc6", {16'd0, ula_input2}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
